// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder.
// State encoding and the slice width used by the datapath.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_ripple_adder.sv
// 4-bit ripple-carry adder slice.
// Time-shared by the sequencer, one nibble per cycle.
module ripple_adder
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             co
);

  // Bit-by-bit ripple; carry is a block-local running variable
  always_comb begin
    logic c;
    c = ci;
    s = '0;
    for (int i = 0; i < NIB_W; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built from one 4-bit slice, LSB nibble first.
// Carry is registered between nibbles; sum/cout held until next result.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / NIB_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIB - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [NIB_W-1:0]       slice_s;
  logic                   slice_co;
  logic [WIDTH+NIB_W-1:0] res_cat;

  ripple_adder u_slice (
    .a  (a_q[NIB_W-1:0]),
    .b  (b_q[NIB_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // Slice result enters at the top so the LSB nibble ends up at bit 0
  assign res_cat = {slice_s, res_q};

  // Next-state, datapath shifts and registered output values
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        a_d     = a_q >> NIB_W;
        b_d     = b_q >> NIB_W;
        res_d   = res_cat[WIDTH+NIB_W-1:NIB_W];
        carry_d = slice_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = res_cat[WIDTH+NIB_W-1:NIB_W];
          cout_d  = slice_co;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ADD);
    done_d = (state_d == DONE);
  end

  // All state and outputs; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Sequencer that performs a WIDTH-bit addition by time-sharing one 4-bit adder slice over WIDTH/4 cycles, least-significant nibble first. The carry is registered between nibbles. The block takes a start/operands request and returns a registered sum, carry-out and a one-cycle done pulse. It is the area-saving alternative to a full-width combinational adder for wide, low-throughput arithmetic.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when the block can accept (IDLE or DONE)
a  input  WIDTH  operand A; captured on an accepted start
b  input  WIDTH  operand B; captured on an accepted start
cin  input  1  carry-in; captured on an accepted start
busy  output  1  high while nibbles are being processed (ADD state)
done  output  1  one-cycle pulse; sum/cout valid from this cycle on
sum  output  WIDTH  registered result, held until the next completion
cout  output  1  registered final carry-out, held with sum

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: busy=0, done=0, sum=0, cout=0; FSM goes to IDLE; nibble counter = 0; carry register = 0.
- FSM states:
  - IDLE: start=1 captures a, b and cin into the A/B shift registers and the carry register, clears the counter, and moves to ADD. Otherwise stay in IDLE.
  - ADD: busy=1. Each cycle the slice adds the low nibbles of the A/B shift registers plus the carry register.
    - The 4-bit slice result shifts into the top of the result shift register; A/B shift right by 4.
    - carry <= slice carry-out; counter increments.
    - When counter = NIB-1, the final nibble completes that cycle and the FSM moves to DONE.
    - sum <= completed result (including the final nibble) and cout <= final carry, registered on that transition.
  - DONE: done=1 for exactly one cycle. start=1 here is accepted exactly as in IDLE (back-to-back operation) and moves to ADD; otherwise move to IDLE.
- Latency: start accepted at edge T -> busy high cycles T+1..T+NIB -> done high in cycle T+NIB+1, with sum/cout valid in that same cycle. Throughput is one result per NIB+1 cycles.
- start while busy=1 is ignored; no queueing, no error flag. a, b and cin may change freely after capture.
- sum and cout change only on the ADD->DONE transition or on reset; they are stable in IDLE and during a subsequent ADD.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned, no overflow flag.
- WIDTH=4: one ADD cycle; done appears 2 cycles after start.
- Reset mid-operation (any state): aborts the operation. All outputs return to reset values the following cycle; no done pulse is emitted for the aborted operation.
- start and rst asserted in the same cycle: rst wins.

Decomposition:
- Shared package: FSM state encoding constants (IDLE, ADD, DONE) and the nibble width constant (4).
- One sub-module: the team's existing 4-bit adder slice ripple_adder, instantiated once as the nibble datapath.
- Counter, shift registers and FSM live in this module.

Test Plan:
- WIDTH=16, a=16'h1234, b=16'h4321, cin=0, start at cycle 0 -> busy cycles 1-4, done in cycle 5, sum=16'h5555, cout=0.
- a=16'hFFFF, b=16'h0001, cin=0 -> carry propagates through all nibbles: sum=16'h0000, cout=1, done in cycle 5. Also a=16'hFFFF, b=16'h0000, cin=1 -> same result.
- Start an op with a=16'h00FF, b=16'h0001; pulse start again with other operands at cycle 2 -> second start ignored, result sum=16'h0100, cout=0, exactly one done pulse.
- Assert rst in cycle 2 of an op -> next cycle busy=0, sum=0, cout=0, no done. A new start afterwards (a=16'h8000, b=16'h8000) -> sum=16'h0000, cout=1.
- Back-to-back: start held high through the done cycle with new operands (a=16'h0001, b=16'h0002) -> second op accepted in the DONE cycle, next done 5 cycles later with sum=16'h0003; first result held until then.
- 1000 random operands at WIDTH=16 and WIDTH=4 -> {cout,sum} matches a+b+cin from the model on every done pulse; done is never wider than one cycle.
